// File: rtl/trap_pkg.sv
// Shared definitions for the trap controller: FSM states, event kinds,
// CSR addresses, cause codes, mstatus bit positions and mstatus update helpers.
// Optional feature macro: TRAP_DEBUG_EN (debug-mode entry/exit).
package trap_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MSTATUS = 3'd2,
    S_W_MCAUSE  = 3'd3,
`ifdef TRAP_DEBUG_EN
    S_W_DPC     = 3'd4,
    S_W_DCSR    = 3'd5,
`endif
    S_M_RET     = 3'd6,
    S_JUMP      = 3'd7
  } state_e;

  // Winning event of the priority encoder; EV_NONE means stay in IDLE.
  typedef enum logic [3:0] {
    EV_NONE    = 4'd0,
    EV_TRIGGER = 4'd1,
    EV_HALT    = 4'd2,
    EV_ILLEGAL = 4'd3,
    EV_ECALL   = 4'd4,
    EV_EBREAK  = 4'd5,
    EV_EXT     = 4'd6,
    EV_TIMER   = 4'd7,
    EV_MRET    = 4'd8,
    EV_DRET    = 4'd9
  } event_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] MCAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] MCAUSE_EBREAK  = 32'h0000_0003;
  localparam logic [31:0] MCAUSE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] MCAUSE_TIMER   = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_EXT     = 32'h8000_000B;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIE_MEIE       = 11;

`ifdef TRAP_DEBUG_EN
  localparam logic [11:0] CSR_DCSR = 12'h7B0;
  localparam logic [11:0] CSR_DPC  = 12'h7B1;
  localparam logic [2:0]  DCSR_CAUSE_TRIGGER = 3'd2;
  localparam logic [2:0]  DCSR_CAUSE_HALT    = 3'd3;
`endif

  // mstatus on trap entry: stash MIE in MPIE, disable interrupts, MPP = machine.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus on mret: restore MIE from MPIE, set MPIE.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_cause_sel.sv
// Combinational priority encoder: picks the single event to service in IDLE
// and its cause code. Optional feature macro: TRAP_DEBUG_EN.
// Every event, including debug requests, needs a valid instruction because its
// PC is what gets saved.
module trap_cause_sel
  import trap_pkg::*;
(
  input  logic        inst_valid_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  input  logic        ext_int_i,
  input  logic        timer_int_i,
  input  logic        mstatus_mie_i,
  input  logic        mie_meie_i,
  input  logic        mie_mtie_i,
  input  logic        trigger_match_i,
  input  logic        halt_req_i,
  input  logic        dret_i,
  input  logic        debug_mode_i,
  output event_e      event_o,
  output logic [31:0] cause_o
);

  logic irq_mask;

`ifdef TRAP_DEBUG_EN
  assign irq_mask = debug_mode_i;
`else
  logic unused_dbg;
  assign irq_mask   = 1'b0;
  assign unused_dbg = ^{trigger_match_i, halt_req_i, dret_i, debug_mode_i};
`endif

  // Fixed-priority selection; lower-priority simultaneous events are dropped.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    event_o = EV_NONE;
    cause_o = '0;
    if (inst_valid_i) begin
`ifdef TRAP_DEBUG_EN
      if (trigger_match_i && !debug_mode_i) begin
        event_o = EV_TRIGGER;
        cause_o = {29'd0, DCSR_CAUSE_TRIGGER};
      end else if (halt_req_i && !debug_mode_i) begin
        event_o = EV_HALT;
        cause_o = {29'd0, DCSR_CAUSE_HALT};
      end else
`endif
      if (illegal_i) begin
        event_o = EV_ILLEGAL;
        cause_o = MCAUSE_ILLEGAL;
      end else if (ecall_i) begin
        event_o = EV_ECALL;
        cause_o = MCAUSE_ECALL;
      end else if (ebreak_i) begin
        event_o = EV_EBREAK;
        cause_o = MCAUSE_EBREAK;
      end else if (ext_int_i && mstatus_mie_i && mie_meie_i && !irq_mask) begin
        event_o = EV_EXT;
        cause_o = MCAUSE_EXT;
      end else if (timer_int_i && mstatus_mie_i && mie_mtie_i && !irq_mask) begin
        event_o = EV_TIMER;
        cause_o = MCAUSE_TIMER;
      end else if (mret_i) begin
        event_o = EV_MRET;
      end
`ifdef TRAP_DEBUG_EN
      else if (dret_i && debug_mode_i) begin
        event_o = EV_DRET;
      end
`endif
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: sequences the CSR writes for exceptions, interrupts and
// mret, then redirects fetch. Optional feature macro: TRAP_DEBUG_EN adds
// debug-mode entry (dpc/dcsr writes, jump to DEBUG_HALT_ADDR) and dret.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [31:0] DEBUG_HALT_ADDR = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  input  logic        ext_int_i,
  input  logic        timer_int_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] dpc_i,
  input  logic [31:0] dcsr_i,
  input  logic        trigger_match_i,
  input  logic        halt_req_i,
  input  logic        dret_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o
);

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] target_q, target_d;
  logic        debug_mode;
  event_e      ev;
  logic [31:0] ev_cause;
  logic        unused_bits;

`ifdef TRAP_DEBUG_EN
  logic debug_mode_q, debug_mode_d;
  assign debug_mode  = debug_mode_q;
  assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:0], mtvec_i[1:0], dcsr_i[8:6]};
`else
  assign debug_mode  = 1'b0;
  assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:0], mtvec_i[1:0],
                         dpc_i, dcsr_i, DEBUG_HALT_ADDR};
`endif

  trap_cause_sel u_cause_sel (
    .inst_valid_i    (inst_valid_i),
    .ecall_i         (ecall_i),
    .ebreak_i        (ebreak_i),
    .illegal_i       (illegal_i),
    .mret_i          (mret_i),
    .ext_int_i       (ext_int_i),
    .timer_int_i     (timer_int_i),
    .mstatus_mie_i   (mstatus_i[MSTATUS_MIE]),
    .mie_meie_i      (mie_i[MIE_MEIE]),
    .mie_mtie_i      (mie_i[MIE_MTIE]),
    .trigger_match_i (trigger_match_i),
    .halt_req_i      (halt_req_i),
    .dret_i          (dret_i),
    .debug_mode_i    (debug_mode),
    .event_o         (ev),
    .cause_o         (ev_cause)
  );

  // State and captured-context registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      target_q <= '0;
`ifdef TRAP_DEBUG_EN
      debug_mode_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      target_q <= target_d;
`ifdef TRAP_DEBUG_EN
      debug_mode_q <= debug_mode_d;
`endif
    end
  end

  // Next-state logic; context is captured only when an event is accepted in IDLE.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    target_d = target_q;
`ifdef TRAP_DEBUG_EN
    debug_mode_d = debug_mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        case (ev)
          EV_ILLEGAL, EV_ECALL, EV_EBREAK, EV_EXT, EV_TIMER: begin
            state_d  = S_W_MEPC;
            cause_d  = ev_cause;
            epc_d    = inst_addr_i;
            target_d = {mtvec_i[31:2], 2'b00};
          end
          EV_MRET: begin
            state_d  = S_M_RET;
            target_d = mepc_i;
          end
`ifdef TRAP_DEBUG_EN
          EV_TRIGGER, EV_HALT: begin
            state_d  = S_W_DPC;
            cause_d  = ev_cause;
            epc_d    = inst_addr_i;
            target_d = DEBUG_HALT_ADDR;
          end
          EV_DRET: begin
            state_d      = S_JUMP;
            target_d     = dpc_i;
            debug_mode_d = 1'b0;
          end
`endif
          default: ;
        endcase
      end
      S_W_MEPC:    state_d = S_W_MSTATUS;
      S_W_MSTATUS: state_d = S_W_MCAUSE;
      S_W_MCAUSE:  state_d = S_JUMP;
      S_M_RET:     state_d = S_JUMP;
`ifdef TRAP_DEBUG_EN
      S_W_DPC:     state_d = S_W_DCSR;
      S_W_DCSR: begin
        state_d      = S_JUMP;
        debug_mode_d = 1'b1;
      end
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode: CSR write port and redirect per state; IDLE stalls on an accepted event.
  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    stall_flag_o = 1'b1;
    jump_flag_o  = 1'b0;
    jump_addr_o  = '0;
    case (state_q)
      S_IDLE: stall_flag_o = (ev != EV_NONE);
      S_W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MEPC};
        csr_wdata_o = epc_q;
      end
      S_W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MSTATUS};
        csr_wdata_o = trap_mstatus(mstatus_i);
      end
      S_W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MCAUSE};
        csr_wdata_o = cause_q;
      end
      S_M_RET: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MSTATUS};
        csr_wdata_o = mret_mstatus(mstatus_i);
      end
`ifdef TRAP_DEBUG_EN
      S_W_DPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_DPC};
        csr_wdata_o = epc_q;
      end
      S_W_DCSR: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_DCSR};
        csr_wdata_o = {dcsr_i[31:9], cause_q[2:0], dcsr_i[5:0]};
      end
`endif
      S_JUMP: begin
        jump_flag_o = 1'b1;
        jump_addr_o = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with hand-computed expected values.
// Debug-mode steps are included when TRAP_DEBUG_EN is defined.
module tb_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic        ecall_i, ebreak_i, illegal_i, mret_i;
  logic        ext_int_i, timer_int_i;
  logic [31:0] mtvec_i, mepc_i, mstatus_i, mie_i, dpc_i, dcsr_i;
  logic        trigger_match_i, halt_req_i, dret_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o, csr_wdata_o;
  logic        stall_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;

  int n_checks = 0;
  int n_pass   = 0;

  trap_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_valid_i    (inst_valid_i),
    .inst_addr_i     (inst_addr_i),
    .ecall_i         (ecall_i),
    .ebreak_i        (ebreak_i),
    .illegal_i       (illegal_i),
    .mret_i          (mret_i),
    .ext_int_i       (ext_int_i),
    .timer_int_i     (timer_int_i),
    .mtvec_i         (mtvec_i),
    .mepc_i          (mepc_i),
    .mstatus_i       (mstatus_i),
    .mie_i           (mie_i),
    .dpc_i           (dpc_i),
    .dcsr_i          (dcsr_i),
    .trigger_match_i (trigger_match_i),
    .halt_req_i      (halt_req_i),
    .dret_i          (dret_i),
    .csr_we_o        (csr_we_o),
    .csr_waddr_o     (csr_waddr_o),
    .csr_wdata_o     (csr_wdata_o),
    .stall_flag_o    (stall_flag_o),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    inst_valid_i    = 1'b0;
    ecall_i         = 1'b0;
    ebreak_i        = 1'b0;
    illegal_i       = 1'b0;
    mret_i          = 1'b0;
    ext_int_i       = 1'b0;
    timer_int_i     = 1'b0;
    trigger_match_i = 1'b0;
    halt_req_i      = 1'b0;
    dret_i          = 1'b0;
  endtask

  // Checks one CSR write cycle.
  task automatic check_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, " we"},    {31'd0, csr_we_o},     32'd1);
    check({tag, " addr"},  csr_waddr_o,           addr);
    check({tag, " data"},  csr_wdata_o,           data);
    check({tag, " stall"}, {31'd0, stall_flag_o}, 32'd1);
  endtask

  task automatic check_jump(input string tag, input logic [31:0] addr);
    check({tag, " flag"},  {31'd0, jump_flag_o},  32'd1);
    check({tag, " addr"},  jump_addr_o,           addr);
    check({tag, " we"},    {31'd0, csr_we_o},     32'd0);
    check({tag, " stall"}, {31'd0, stall_flag_o}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " stall"}, {31'd0, stall_flag_o}, 32'd0);
    check({tag, " we"},    {31'd0, csr_we_o},     32'd0);
    check({tag, " jump"},  {31'd0, jump_flag_o},  32'd0);
  endtask

  initial begin
    clear_events();
    rst_n       = 1'b0;
    inst_addr_i = '0;
    mtvec_i     = '0;
    mepc_i      = '0;
    mstatus_i   = '0;
    mie_i       = '0;
    dpc_i       = '0;
    dcsr_i      = '0;
    tick();
    tick();

    // Reset state
    check_idle("reset");
    check("reset waddr", csr_waddr_o, 32'h0);
    check("reset wdata", csr_wdata_o, 32'h0);
    check("reset jaddr", jump_addr_o, 32'h0);
    rst_n = 1'b1;
    tick();

    // ecall at 0x100, mtvec 0x205 -> jump 0x204
    mstatus_i    = 32'h0000_0008;
    mtvec_i      = 32'h0000_0205;
    inst_addr_i  = 32'h0000_0100;
    inst_valid_i = 1'b1;
    ecall_i      = 1'b1;
    #1;
    check("ecall N stall", {31'd0, stall_flag_o}, 32'd1);
    check("ecall N we", {31'd0, csr_we_o}, 32'd0);
    tick();
    clear_events();
    inst_addr_i = 32'h0000_0999;
    #1;
    check_write("ecall mepc", 32'h341, 32'h0000_0100);
    tick();
    mret_i = 1'b1;  // arrives outside IDLE, must be ignored
    inst_valid_i = 1'b1;
    #1;
    check_write("ecall mstatus", 32'h300, 32'h0000_1880);
    tick();
    clear_events();
    #1;
    check_write("ecall mcause", 32'h342, 32'h0000_000B);
    tick();
    check_jump("ecall jump", 32'h0000_0204);
    tick();
    check_idle("ecall done");

    // External interrupt enabled at PC 0x40
    mstatus_i    = 32'h0000_0008;
    mie_i        = 32'h0000_0800;
    mtvec_i      = 32'h0000_1000;
    inst_addr_i  = 32'h0000_0040;
    inst_valid_i = 1'b1;
    ext_int_i    = 1'b1;
    #1;
    check("ext N stall", {31'd0, stall_flag_o}, 32'd1);
    tick();
    clear_events();
    #1;
    check_write("ext mepc", 32'h341, 32'h0000_0040);
    tick();
    tick();
    check_write("ext mcause", 32'h342, 32'h8000_000B);
    tick();
    check_jump("ext jump", 32'h0000_1000);
    tick();

    // External interrupt pending but masked by mie, by MIE, or without a valid instruction
    mie_i        = 32'h0;
    inst_valid_i = 1'b1;
    ext_int_i    = 1'b1;
    #1;
    check_idle("ext mie=0");
    tick();
    check_idle("ext mie=0 next");
    mie_i     = 32'h0000_0800;
    mstatus_i = 32'h0;
    #1;
    check_idle("ext MIE=0");
    mstatus_i    = 32'h0000_0008;
    inst_valid_i = 1'b0;
    #1;
    check_idle("ext no valid");
    clear_events();
    tick();

    // mret: mstatus 0x80 -> 0x88, jump to mepc 0x300
    mstatus_i    = 32'h0000_0080;
    mepc_i       = 32'h0000_0300;
    inst_valid_i = 1'b1;
    mret_i       = 1'b1;
    #1;
    check("mret N stall", {31'd0, stall_flag_o}, 32'd1);
    tick();
    clear_events();
    #1;
    check_write("mret mstatus", 32'h300, 32'h0000_0088);
    tick();
    check_jump("mret jump", 32'h0000_0300);
    tick();
    check_idle("mret done");

    // Illegal and timer together: illegal wins, timer taken afterwards
    mstatus_i    = 32'h0000_0008;
    mie_i        = 32'h0000_0080;
    mtvec_i      = 32'h0000_2001;
    inst_addr_i  = 32'h0000_0200;
    inst_valid_i = 1'b1;
    illegal_i    = 1'b1;
    timer_int_i  = 1'b1;
    #1;
    check("ill N stall", {31'd0, stall_flag_o}, 32'd1);
    tick();
    illegal_i   = 1'b0;
    inst_addr_i = 32'h0000_2000;
    #1;
    check_write("ill mepc", 32'h341, 32'h0000_0200);
    tick();
    tick();
    check_write("ill mcause", 32'h342, 32'h0000_0002);
    tick();
    check_jump("ill jump", 32'h0000_2000);
    tick();
    check("timer N stall", {31'd0, stall_flag_o}, 32'd1);
    tick();
    timer_int_i = 1'b0;
    #1;
    check_write("timer mepc", 32'h341, 32'h0000_2000);
    tick();
    tick();
    check_write("timer mcause", 32'h342, 32'h8000_0007);
    tick();
    check_jump("timer jump", 32'h0000_2000);
    clear_events();
    tick();
    check_idle("timer done");

    // Reset during W_MSTATUS abandons the sequence
    mstatus_i    = 32'h0000_0008;
    inst_addr_i  = 32'h0000_0500;
    inst_valid_i = 1'b1;
    ebreak_i     = 1'b1;
    tick();
    clear_events();
    tick();
    check_write("rst mstatus", 32'h300, 32'h0000_1880);
    rst_n = 1'b0;
    tick();
    check_idle("rst mid");
    rst_n = 1'b1;
    tick();
    check_idle("rst after");
    tick();
    check_idle("rst after2");

`ifdef TRAP_DEBUG_EN
    // Trigger at PC 0x80 -> dpc/dcsr writes, jump to 0x800
    dcsr_i          = 32'h4000_0003;
    inst_addr_i     = 32'h0000_0080;
    inst_valid_i    = 1'b1;
    trigger_match_i = 1'b1;
    #1;
    check("dbg N stall", {31'd0, stall_flag_o}, 32'd1);
    tick();
    clear_events();
    #1;
    check_write("dbg dpc", 32'h7B1, 32'h0000_0080);
    tick();
    check_write("dbg dcsr", 32'h7B0, 32'h4000_0083);
    tick();
    check_jump("dbg jump", 32'h0000_0800);
    tick();
    check_idle("dbg done");
    // In debug mode interrupts and triggers are masked
    mstatus_i       = 32'h0000_0008;
    mie_i           = 32'h0000_0880;
    inst_valid_i    = 1'b1;
    ext_int_i       = 1'b1;
    trigger_match_i = 1'b1;
    #1;
    check_idle("dbg masked");
    clear_events();
    dpc_i        = 32'h0000_0080;
    inst_valid_i = 1'b1;
    dret_i       = 1'b1;
    #1;
    check("dret N stall", {31'd0, stall_flag_o}, 32'd1);
    tick();
    clear_events();
    #1;
    check_jump("dret jump", 32'h0000_0080);
    tick();
    check_idle("dret done");
`else
    // Debug requests have no effect in this build
    inst_addr_i     = 32'h0000_0080;
    inst_valid_i    = 1'b1;
    trigger_match_i = 1'b1;
    halt_req_i      = 1'b1;
    dret_i          = 1'b1;
    #1;
    check_idle("nodbg req");
    tick();
    check_idle("nodbg next");
    clear_events();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter DEBUG_HALT_ADDR, default 32'h0000_0800, debug-mode entry address.
REQ-002 SHALL have one clock; reset is synchronous and active-low; ports are clk and rst_n.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 inst_valid_i  in  1  exu holds a valid, not-yet-committed instruction.
REQ-006 inst_addr_i  in  32  PC of that instruction.
REQ-007 ecall_i, ebreak_i, illegal_i, mret_i  in  1 each  decoded events, qualified by inst_valid_i.
REQ-008 ext_int_i, timer_int_i  in  1 each  level interrupt requests.
REQ-009 mtvec_i, mepc_i, mstatus_i, mie_i, dpc_i, dcsr_i  in  32 each  current CSR values.
REQ-010 trigger_match_i, halt_req_i, dret_i  in  1 each  debug entry/exit requests.
REQ-011 csr_we_o  out  1  CSR write strobe (exception write port).
REQ-012 csr_waddr_o  out  32  CSR address, zero-extended 12-bit.
REQ-013 csr_wdata_o  out  32  CSR write data.
REQ-014 stall_flag_o  out  1  freeze pipeline, block exu CSR writes.
REQ-015 jump_flag_o, jump_addr_o  out  1 / 32  redirect fetch, flush pipeline.

Function
REQ-016 States SHALL be IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_DPC, W_DCSR, M_RET, JUMP.
REQ-017 Priority in IDLE SHALL be: debug (trigger > halt) > illegal > ecall/ebreak > external int > timer int > mret/dret.
REQ-018 Interrupt SHALL be taken only if inst_valid_i, mstatus_i[3]=1, and mie_i[11] (ext) or mie_i[7] (timer).
REQ-019 On event in IDLE (cycle N), stall_flag_o SHALL assert combinationally in N; cause, inst_addr_i and target SHALL be registered.
REQ-020 Trap sequence: N+1 W_MEPC writes 0x341 = captured PC; N+2 W_MSTATUS writes 0x300; N+3 W_MCAUSE writes 0x342; N+4 JUMP.
REQ-021 Trap mstatus data: MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11, other bits from mstatus_i.
REQ-022 mcause SHALL be: illegal 2, ebreak 3, ecall 11, timer 0x8000_0007, external 0x8000_000B.
REQ-023 mret: N+1 M_RET writes mstatus with MIE=MPIE, MPIE=1; N+2 JUMP to mepc_i.
REQ-024 JUMP SHALL pulse jump_flag_o one cycle; trap target = {mtvec_i[31:2],2'b00} (direct mode only).
REQ-025 stall_flag_o SHALL be 1 in every non-IDLE state; csr_we_o is 1 only in W_* and M_RET states.
REQ-026 Events arriving outside IDLE SHALL be ignored; level interrupts still held are re-evaluated on return to IDLE.
REQ-027 Simultaneous events: only the highest-priority one SHALL be serviced; others are not queued.

Reset
REQ-028 On rst_n=0 at a clock edge: state=IDLE, debug_mode=0, captured regs=0, all outputs 0.
REQ-029 Reset mid-sequence SHALL abandon it with no further CSR writes.

Configuration
REQ-030 Macro TRAP_DEBUG_EN compiled in: trigger/halt in IDLE with debug_mode=0 -> W_DPC writes 0x7B1 = PC, W_DCSR writes 0x7B0 with dcsr_i and [8:6]=2 (trigger) or 3 (halt), JUMP to DEBUG_HALT_ADDR, set debug_mode.
REQ-031 With TRAP_DEBUG_EN: in debug_mode, interrupts and triggers are masked; dret_i -> JUMP to dpc_i, clear debug_mode.
REQ-032 Without TRAP_DEBUG_EN: trigger_match_i, halt_req_i, dret_i ignored; W_DPC/W_DCSR states and debug_mode absent.

Structure
REQ-033 State enum, CSR addresses, mcause codes and mstatus bit positions SHALL live in shared package trap_pkg.
REQ-034 Priority/cause encoding SHALL be one combinational sub-module trap_cause_sel.

Verification
REQ-035 ecall_i at PC 0x100, mtvec_i=0x205 -> writes mepc=0x100, mstatus MIE 1->0/MPIE=1, mcause=11; jump to 0x204 at N+4.
REQ-036 ext_int_i with mstatus_i=0x8, mie_i=0x800, PC 0x40 -> mcause 0x8000_000B, mepc 0x40; with mie_i=0 -> no trap.
REQ-037 mret_i, mstatus_i=0x80, mepc_i=0x300 -> mstatus write 0x88; jump to 0x300 at N+2.
REQ-038 illegal_i and timer interrupt same cycle -> mcause 2 only; timer taken after return to IDLE if still pending.
REQ-039 rst_n low during W_MSTATUS -> next cycle IDLE, csr_we_o=0, stall_flag_o=0.
REQ-040 With TRAP_DEBUG_EN, trigger_match_i at PC 0x80 -> dpc=0x80, dcsr[8:6]=2, jump 0x800; dret_i -> jump to dpc_i.
